// File: rtl/fft_peak_tracker.sv
// fft_peak_tracker: per-frame spectral peak, peak |X|^2 and band energy.
// Optional build macro PEAK_DECAY_EN adds a decaying peak-hold output.
module fft_peak_tracker #(
   parameter int DATA_WIDTH  = 24,
   parameter int FFT_SIZE    = 256,
   parameter int BIN_LO      = 1,
   parameter int BIN_HI      = 127,
   parameter int DECAY_SHIFT = 3
) (
   input  logic                                       clk_i,
   input  logic                                       rst_i,
   input  logic [DATA_WIDTH-1:0]                      data_real_i,
   input  logic [DATA_WIDTH-1:0]                      data_imag_i,
   input  logic                                       first_i,
   input  logic                                       valid_i,
   output logic                                       ready_o,
   output logic [$clog2(FFT_SIZE)-1:0]                peak_bin_o,
   output logic [2*DATA_WIDTH-1:0]                    peak_mag_o,
   output logic [2*DATA_WIDTH+$clog2(FFT_SIZE)-1:0]   energy_o,
   output logic [2*DATA_WIDTH-1:0]                    hold_mag_o,
   output logic                                       res_valid_o,
   input  logic                                       res_ready_i,
   output logic [5:0]                                 led_o,
   output logic                                       overrun_o,
   output logic                                       frame_err_o
);

   localparam int BIN_W = $clog2(FFT_SIZE);
   localparam int MAG_W = 2 * DATA_WIDTH;
   localparam int EN_W  = MAG_W + BIN_W;

   localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(FFT_SIZE - 1);
   localparam logic [BIN_W-1:0] LO_BIN   = BIN_W'(BIN_LO);
   localparam logic [BIN_W-1:0] HI_BIN   = BIN_W'(BIN_HI);
   localparam logic [BIN_W-1:0] ONE_BIN  = BIN_W'(1);

   localparam bit CFG_OK = (FFT_SIZE >= 4)
                         && ((FFT_SIZE & (FFT_SIZE - 1)) == 0)
                         && (BIN_LO >= 0)
                         && (BIN_LO <= BIN_HI)
                         && (BIN_HI < FFT_SIZE)
                         && (DECAY_SHIFT >= 0)
                         && (DATA_WIDTH >= 2);

   if (!CFG_OK) begin : g_cfg_err
      $error("fft_peak_tracker: illegal parameter set");
   end

   // ---------------------------------------------------------------
   // Input acceptance and bin numbering
   // ---------------------------------------------------------------
   logic                    accept;
   logic [BIN_W-1:0]        cnt;
   logic [BIN_W-1:0]        beat_bin;

   logic                    s0_vld;
   logic signed [DATA_WIDTH-1:0] s0_re;
   logic signed [DATA_WIDTH-1:0] s0_im;
   logic [BIN_W-1:0]        s0_bin;

   assign accept   = valid_i & ready_o;
   assign beat_bin = first_i ? '0 : cnt;

   // Ready comes up on the first edge after reset and never drops.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) ready_o <= 1'b0;
      else       ready_o <= 1'b1;
   end

   // Capture the accepted beat, number it, and flag mid-frame resyncs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt         <= '0;
         s0_vld      <= 1'b0;
         s0_re       <= '0;
         s0_im       <= '0;
         s0_bin      <= '0;
         frame_err_o <= 1'b0;
      end else begin
         s0_vld      <= accept;
         frame_err_o <= accept & first_i & (cnt != '0);
         if (accept) begin
            cnt    <= beat_bin + ONE_BIN;
            s0_re  <= data_real_i;
            s0_im  <= data_imag_i;
            s0_bin <= beat_bin;
         end
      end
   end

   // ---------------------------------------------------------------
   // Stage 1: squares
   // ---------------------------------------------------------------
   logic signed [MAG_W-1:0] re_ext;
   logic signed [MAG_W-1:0] im_ext;
   logic signed [MAG_W-1:0] re_sq;
   logic signed [MAG_W-1:0] im_sq;
   logic                    s0_band;

   assign re_ext  = MAG_W'(s0_re);
   assign im_ext  = MAG_W'(s0_im);
   assign re_sq   = re_ext * re_ext;
   assign im_sq   = im_ext * im_ext;
   assign s0_band = (s0_bin >= LO_BIN) && (s0_bin <= HI_BIN);

   logic                    s1_vld;
   logic [MAG_W-1:0]        s1_re2;
   logic [MAG_W-1:0]        s1_im2;
   logic [BIN_W-1:0]        s1_bin;
   logic                    s1_band;

   // Register both squares with the bin index and its band flag.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_vld  <= 1'b0;
         s1_re2  <= '0;
         s1_im2  <= '0;
         s1_bin  <= '0;
         s1_band <= 1'b0;
      end else begin
         s1_vld <= s0_vld;
         if (s0_vld) begin
            s1_re2  <= re_sq;
            s1_im2  <= im_sq;
            s1_bin  <= s0_bin;
            s1_band <= s0_band;
         end
      end
   end

   // ---------------------------------------------------------------
   // Stage 2: magnitude, running max and band energy
   // ---------------------------------------------------------------
   logic                    s2_vld;
   logic [MAG_W-1:0]        s2_mag;
   logic [BIN_W-1:0]        s2_bin;
   logic                    s2_band;

   // Squares are non-negative and each at most 2^(2W-2), so the sum fits.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s2_vld  <= 1'b0;
         s2_mag  <= '0;
         s2_bin  <= '0;
         s2_band <= 1'b0;
      end else begin
         s2_vld <= s1_vld;
         if (s1_vld) begin
            s2_mag  <= s1_re2 + s1_im2;
            s2_bin  <= s1_bin;
            s2_band <= s1_band;
         end
      end
   end

   logic [MAG_W-1:0]        run_max;
   logic [BIN_W-1:0]        run_bin;
   logic [EN_W-1:0]         run_en;
   logic [MAG_W-1:0]        base_max;
   logic [BIN_W-1:0]        base_bin;
   logic [EN_W-1:0]         base_en;
   logic [MAG_W-1:0]        nxt_max;
   logic [BIN_W-1:0]        nxt_bin;
   logic [EN_W-1:0]         nxt_en;
   logic                    close;

   assign close = s2_vld & (s2_bin == LAST_BIN);

   // Bin 0 always opens a fresh frame, which also drops any partial one.
   always_comb begin
      base_max = run_max;
      base_bin = run_bin;
      base_en  = run_en;
      if (s2_bin == '0) begin
         base_max = '0;
         base_bin = LO_BIN;
         base_en  = '0;
      end
      nxt_max = base_max;
      nxt_bin = base_bin;
      nxt_en  = base_en;
      if (s2_band) begin
         nxt_en = base_en + EN_W'(s2_mag);
         if (s2_mag > base_max) begin
            nxt_max = s2_mag;
            nxt_bin = s2_bin;
         end
      end
   end

   // Running accumulators; cleared right after the last bin is folded in.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         run_max <= '0;
         run_bin <= LO_BIN;
         run_en  <= '0;
      end else if (s2_vld) begin
         if (close) begin
            run_max <= '0;
            run_bin <= LO_BIN;
            run_en  <= '0;
         end else begin
            run_max <= nxt_max;
            run_bin <= nxt_bin;
            run_en  <= nxt_en;
         end
      end
   end

   // ---------------------------------------------------------------
   // Result port
   // ---------------------------------------------------------------
   logic                    res_free;

   assign res_free = ~res_valid_o | res_ready_i;

   // Load on frame close if the slot is free; otherwise drop and flag.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         peak_bin_o  <= '0;
         peak_mag_o  <= '0;
         energy_o    <= '0;
         res_valid_o <= 1'b0;
         overrun_o   <= 1'b0;
      end else begin
         overrun_o <= 1'b0;
         if (close) begin
            if (res_free) begin
               peak_bin_o  <= nxt_bin;
               peak_mag_o  <= nxt_max;
               energy_o    <= nxt_en;
               res_valid_o <= 1'b1;
            end else begin
               overrun_o <= 1'b1;
            end
         end else if (res_valid_o && res_ready_i) begin
            res_valid_o <= 1'b0;
         end
      end
   end

   if (BIN_W >= 6) begin : g_led_wide
      assign led_o = peak_bin_o[BIN_W-1 -: 6];
   end else begin : g_led_narrow
      assign led_o = 6'(peak_bin_o);
   end

`ifdef PEAK_DECAY_EN
   logic [MAG_W-1:0]        hold;
   logic [MAG_W-1:0]        hold_dec;

   assign hold_dec = hold - (hold >> DECAY_SHIFT);

   // Peak hold: new frame peak or the decayed hold, whichever is larger.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hold <= '0;
      end else if (close) begin
         hold <= (nxt_max > hold_dec) ? nxt_max : hold_dec;
      end
   end

   assign hold_mag_o = hold;
`else
   assign hold_mag_o = '0;
`endif

endmodule
